modexp_dispatcher: RTL and testbench

- Schedules RSA modular-exponentiation jobs (M^E mod N) across NUM_ENG identical modexp engines.
- Accepts jobs on a valid/ready port and issues each job to a free engine using the LOAD / GO / DONE protocol.
- Captures each engine's RESULT and returns it, tagged, on a single valid/ready result port.
- Sits between the stimulus/control front end and the engine array in the work-distribution design.

---
 rtl/modexp_dispatcher.sv | 239 +++++++++++++++++++++++
 tb/tb_modexp_dispatcher.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_dispatcher.sv
// Dispatches M^E mod N jobs over NUM_ENG modexp engines (LOAD/GO/DONE) and returns tagged results.
// Define MODEXP_TIMEOUT_EN to abort engines that stay BUSY for TIMEOUT_CYCLES.
module modexp_dispatcher #(
   parameter int unsigned BITS           = 32,
   parameter int unsigned NUM_ENG        = 4,
   parameter int unsigned TAG_W          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    JOB_VALID,
   output logic                    JOB_READY,
   input  logic [BITS-1:0]         JOB_M,
   input  logic [BITS-1:0]         JOB_E,
   input  logic [BITS-1:0]         JOB_N,
   input  logic [TAG_W-1:0]        JOB_TAG,
   output logic [BITS-1:0]         ENG_M,
   output logic [BITS-1:0]         ENG_E,
   output logic [BITS-1:0]         ENG_N,
   output logic [NUM_ENG-1:0]      ENG_LOAD,
   output logic [NUM_ENG-1:0]      ENG_GO,
   input  logic [NUM_ENG-1:0]      ENG_DONE,
   input  logic [NUM_ENG*BITS-1:0] ENG_RESULT,
   output logic                    RES_VALID,
   input  logic                    RES_READY,
   output logic [BITS-1:0]         RES_DATA,
   output logic [TAG_W-1:0]        RES_TAG,
   output logic                    RES_ERR,
   output logic [NUM_ENG-1:0]      ENG_BUSY,
   output logic [15:0]             JOBS_DONE
);

   localparam int unsigned PTR_W = $clog2(NUM_ENG);

   typedef enum logic [1:0] {SlIdle, SlLoad, SlBusy, SlHold} slot_st_e;

   slot_st_e         slot_st_q [NUM_ENG];
   slot_st_e         slot_st_d [NUM_ENG];
   logic [TAG_W-1:0] tag_q [NUM_ENG];
   logic [TAG_W-1:0] tag_d [NUM_ENG];
   logic [BITS-1:0]  res_q [NUM_ENG];
   logic [BITS-1:0]  res_d [NUM_ENG];

   logic [PTR_W-1:0] disp_ptr_q, disp_ptr_d;
   logic [PTR_W-1:0] out_ptr_q, out_ptr_d;
   logic [PTR_W-1:0] gnt_q, gnt_d;
   logic             res_valid_q, res_valid_d;
   logic [BITS-1:0]  res_data_q, res_data_d;
   logic [TAG_W-1:0] res_tag_q, res_tag_d;
   logic [BITS-1:0]  eng_m_q, eng_m_d;
   logic [BITS-1:0]  eng_e_q, eng_e_d;
   logic [BITS-1:0]  eng_n_q, eng_n_d;
   logic [15:0]      jobs_done_q, jobs_done_d;

`ifdef MODEXP_TIMEOUT_EN
   logic [31:0]      cnt_q [NUM_ENG];
   logic [31:0]      cnt_d [NUM_ENG];
   logic             err_q [NUM_ENG];
   logic             err_d [NUM_ENG];
   logic             res_err_q, res_err_d;
`endif

   logic [NUM_ENG-1:0] elig;
   logic [NUM_ENG-1:0] hold;
   logic [PTR_W:0]     acc_pick;
   logic [PTR_W:0]     out_pick;
   logic               accept;
   logic               hs;

   // Returns {found, index} of the first request strictly after ptr, wrapping.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_ENG-1:0] req,
                                              input logic [PTR_W-1:0]   ptr);
      logic [PTR_W:0] pick;
      int unsigned    idx;
      pick = '0;
      for (int unsigned k = 1; k <= NUM_ENG; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NUM_ENG) idx = idx - NUM_ENG;
         if (!pick[PTR_W] && req[idx[PTR_W-1:0]]) pick = {1'b1, idx[PTR_W-1:0]};
      end
      return pick;
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < NUM_ENG; i++) begin
         elig[i]     = (slot_st_q[i] == SlIdle) && !ENG_DONE[i];
         hold[i]     = (slot_st_q[i] == SlHold);
         ENG_LOAD[i] = (slot_st_q[i] == SlLoad);
         ENG_GO[i]   = (slot_st_q[i] == SlBusy);
         ENG_BUSY[i] = (slot_st_q[i] != SlIdle);
      end
   end

   assign acc_pick  = rr_pick(elig, disp_ptr_q);
   assign out_pick  = rr_pick(hold, out_ptr_q);
   assign JOB_READY = acc_pick[PTR_W];
   assign accept    = JOB_VALID && acc_pick[PTR_W];
   assign hs        = res_valid_q && RES_READY;

   always_comb begin
      slot_st_d   = slot_st_q;
      tag_d       = tag_q;
      res_d       = res_q;
      disp_ptr_d  = disp_ptr_q;
      out_ptr_d   = out_ptr_q;
      gnt_d       = gnt_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_tag_d   = res_tag_q;
      eng_m_d     = eng_m_q;
      eng_e_d     = eng_e_q;
      eng_n_d     = eng_n_q;
      jobs_done_d = jobs_done_q;
`ifdef MODEXP_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
      res_err_d   = res_err_q;
`endif

      if (accept) begin
         disp_ptr_d = acc_pick[PTR_W-1:0];
         eng_m_d    = JOB_M;
         eng_e_d    = JOB_E;
         eng_n_d    = JOB_N;
      end

      for (int unsigned i = 0; i < NUM_ENG; i++) begin
         unique case (slot_st_q[i])
            SlIdle: begin
               if (accept && acc_pick[PTR_W-1:0] == PTR_W'(i)) begin
                  slot_st_d[i] = SlLoad;
                  tag_d[i]     = JOB_TAG;
               end
            end
            SlLoad: begin
               slot_st_d[i] = SlBusy;
`ifdef MODEXP_TIMEOUT_EN
               cnt_d[i]     = '0;
`endif
            end
            SlBusy: begin
               // DONE takes priority over a timeout expiring in the same cycle.
               if (ENG_DONE[i]) begin
                  slot_st_d[i] = SlHold;
                  res_d[i]     = ENG_RESULT[i*BITS +: BITS];
`ifdef MODEXP_TIMEOUT_EN
                  err_d[i]     = 1'b0;
               end else if (cnt_q[i] + 32'd1 >= TIMEOUT_CYCLES) begin
                  slot_st_d[i] = SlHold;
                  res_d[i]     = '1;
                  err_d[i]     = 1'b1;
               end else begin
                  cnt_d[i]     = cnt_q[i] + 32'd1;
`endif
               end
            end
            SlHold: begin
               if (hs && gnt_q == PTR_W'(i)) slot_st_d[i] = SlIdle;
            end
            default: slot_st_d[i] = SlIdle;
         endcase
      end

      // A grant is only taken while the output register is empty, so each result costs 2 cycles.
      if (hs) begin
         res_valid_d = 1'b0;
         out_ptr_d   = gnt_q;
         jobs_done_d = jobs_done_q + 16'd1;
      end else if (!res_valid_q && out_pick[PTR_W]) begin
         res_valid_d = 1'b1;
         gnt_d       = out_pick[PTR_W-1:0];
         res_data_d  = res_q[out_pick[PTR_W-1:0]];
         res_tag_d   = tag_q[out_pick[PTR_W-1:0]];
`ifdef MODEXP_TIMEOUT_EN
         res_err_d   = err_q[out_pick[PTR_W-1:0]];
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int unsigned i = 0; i < NUM_ENG; i++) begin
            slot_st_q[i] <= SlIdle;
            tag_q[i]     <= '0;
            res_q[i]     <= '0;
`ifdef MODEXP_TIMEOUT_EN
            cnt_q[i]     <= '0;
            err_q[i]     <= 1'b0;
`endif
         end
         disp_ptr_q  <= PTR_W'(NUM_ENG - 1);
         out_ptr_q   <= PTR_W'(NUM_ENG - 1);
         gnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_tag_q   <= '0;
         eng_m_q     <= '0;
         eng_e_q     <= '0;
         eng_n_q     <= '0;
         jobs_done_q <= '0;
`ifdef MODEXP_TIMEOUT_EN
         res_err_q   <= 1'b0;
`endif
      end else begin
         slot_st_q   <= slot_st_d;
         tag_q       <= tag_d;
         res_q       <= res_d;
         disp_ptr_q  <= disp_ptr_d;
         out_ptr_q   <= out_ptr_d;
         gnt_q       <= gnt_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_tag_q   <= res_tag_d;
         eng_m_q     <= eng_m_d;
         eng_e_q     <= eng_e_d;
         eng_n_q     <= eng_n_d;
         jobs_done_q <= jobs_done_d;
`ifdef MODEXP_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         res_err_q   <= res_err_d;
`endif
      end
   end

   assign ENG_M     = eng_m_q;
   assign ENG_E     = eng_e_q;
   assign ENG_N     = eng_n_q;
   assign RES_VALID = res_valid_q;
   assign RES_DATA  = res_data_q;
   assign RES_TAG   = res_tag_q;
   assign JOBS_DONE = jobs_done_q;
`ifdef MODEXP_TIMEOUT_EN
   assign RES_ERR   = res_err_q;
`else
   assign RES_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_modexp_dispatcher.sv
// Bench for modexp_dispatcher: behavioural engine array, timestamp-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_modexp_dispatcher;

   localparam int unsigned BITS = 32;
   localparam int unsigned NE   = 4;
   localparam int unsigned TW   = 4;
`ifdef MODEXP_TIMEOUT_EN
   localparam int unsigned TO   = 50;
`else
   localparam int unsigned TO   = 65535;
`endif

   logic              CLK = 1'b0;
   logic              RESET;
   logic              JOB_VALID;
   logic              JOB_READY;
   logic [BITS-1:0]   JOB_M, JOB_E, JOB_N;
   logic [TW-1:0]     JOB_TAG;
   logic [BITS-1:0]   ENG_M, ENG_E, ENG_N;
   logic [NE-1:0]     ENG_LOAD, ENG_GO, ENG_DONE, ENG_BUSY;
   logic [NE*BITS-1:0] ENG_RESULT;
   logic              RES_VALID, RES_READY, RES_ERR;
   logic [BITS-1:0]   RES_DATA;
   logic [TW-1:0]     RES_TAG;
   logic [15:0]       JOBS_DONE;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   modexp_dispatcher #(
      .BITS(BITS), .NUM_ENG(NE), .TAG_W(TW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .JOB_VALID(JOB_VALID), .JOB_READY(JOB_READY),
      .JOB_M(JOB_M), .JOB_E(JOB_E), .JOB_N(JOB_N), .JOB_TAG(JOB_TAG),
      .ENG_M(ENG_M), .ENG_E(ENG_E), .ENG_N(ENG_N),
      .ENG_LOAD(ENG_LOAD), .ENG_GO(ENG_GO), .ENG_DONE(ENG_DONE), .ENG_RESULT(ENG_RESULT),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
      .RES_TAG(RES_TAG), .RES_ERR(RES_ERR), .ENG_BUSY(ENG_BUSY), .JOBS_DONE(JOBS_DONE)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- engine array: DONE after eng_lat GO cycles (0 = never) or on fin_req
   logic [BITS-1:0] eng_res   [NE];
   int              eng_lat   [NE];
   int              eng_extra [NE];
   int              eng_cnt   [NE];
   int              eng_hold  [NE];
   logic [NE-1:0]   fin_req;

   always_comb begin
      ENG_RESULT = '0;
      for (int i = 0; i < NE; i++) ENG_RESULT[i*BITS +: BITS] = eng_res[i];
   end

   always @(posedge CLK) begin
      for (int i = 0; i < NE; i++) begin
         if (RESET) begin
            ENG_DONE[i] <= 1'b0;
            eng_cnt[i]  <= 0;
            eng_hold[i] <= 0;
         end else if (ENG_GO[i]) begin
            if (!ENG_DONE[i]) begin
               eng_cnt[i] <= eng_cnt[i] + 1;
               if ((eng_lat[i] != 0 && eng_cnt[i] + 1 >= eng_lat[i]) || fin_req[i])
                  ENG_DONE[i] <= 1'b1;
            end
         end else if (ENG_DONE[i]) begin
            if (eng_hold[i] >= eng_extra[i]) begin
               ENG_DONE[i] <= 1'b0;
               eng_cnt[i]  <= 0;
               eng_hold[i] <= 0;
            end else begin
               eng_hold[i] <= eng_hold[i] + 1;
            end
         end else begin
            eng_cnt[i] <= 0;
         end
      end
   end

   // ---------------- reference model: each slot is a job with accept/capture timestamps
   bit              m_live = 1'b0;
   int              cyc;
   bit              m_occ  [NE];
   bit              m_hold [NE];
   int              m_acc  [NE];
   logic [TW-1:0]   m_tag  [NE];
   logic [BITS-1:0] m_res  [NE];
   bit              m_err  [NE];
   int              m_dptr, m_optr, m_gnt;
   bit              m_valid, m_rerr;
   logic [BITS-1:0] m_data, m_m, m_e, m_n;
   logic [TW-1:0]   m_rtag;
   logic [15:0]     m_jobs;

   function automatic int rr_first(input logic [NE-1:0] req, input int ptr);
      for (int k = 1; k <= NE; k++) if (req[(ptr + k) % NE]) return (ptr + k) % NE;
      return -1;
   endfunction

   always @(posedge CLK) begin
      logic [NE-1:0] elig, heldv;
      int a_sel, g_sel;
      bit hs, run;
      if (RESET) begin
         m_live = 1'b1;
         cyc = 0;
         for (int i = 0; i < NE; i++) begin
            m_occ[i] = 0; m_hold[i] = 0; m_acc[i] = 0; m_tag[i] = '0; m_res[i] = '0; m_err[i] = 0;
         end
         m_dptr = NE - 1; m_optr = NE - 1; m_gnt = 0;
         m_valid = 0; m_rerr = 0; m_data = '0; m_rtag = '0; m_jobs = '0;
         m_m = '0; m_e = '0; m_n = '0;
      end else if (m_live) begin
         for (int i = 0; i < NE; i++) begin
            elig[i]  = !m_occ[i] && !ENG_DONE[i];
            heldv[i] = m_hold[i];
         end
         hs    = m_valid && RES_READY;
         a_sel = JOB_VALID ? rr_first(elig, m_dptr) : -1;
         g_sel = !m_valid ? rr_first(heldv, m_optr) : -1;
         for (int i = 0; i < NE; i++) begin
            run = m_occ[i] && !m_hold[i] && (cyc >= m_acc[i] + 2);
            if (run && ENG_DONE[i]) begin
               m_hold[i] = 1; m_res[i] = eng_res[i]; m_err[i] = 0;
`ifdef MODEXP_TIMEOUT_EN
            end else if (run && (cyc - (m_acc[i] + 2) + 1 >= int'(TO))) begin
               m_hold[i] = 1; m_res[i] = '1; m_err[i] = 1;
`endif
            end
         end
         if (hs) begin
            m_occ[m_gnt] = 0; m_hold[m_gnt] = 0; m_optr = m_gnt; m_jobs = m_jobs + 16'd1;
            m_valid = 0;
         end else if (g_sel >= 0) begin
            m_valid = 1; m_gnt = g_sel;
            m_data = m_res[g_sel]; m_rtag = m_tag[g_sel]; m_rerr = m_err[g_sel];
         end
         if (a_sel >= 0) begin
            m_occ[a_sel] = 1; m_acc[a_sel] = cyc; m_tag[a_sel] = JOB_TAG; m_dptr = a_sel;
            m_m = JOB_M; m_e = JOB_E; m_n = JOB_N;
         end
         cyc++;
      end
   end

   always @(negedge CLK) begin
      logic [NE-1:0] e_load, e_go, e_busy;
      bit e_ready;
      if (m_live) begin
         e_ready = 0;
         for (int i = 0; i < NE; i++) begin
            e_load[i] = m_occ[i] && !m_hold[i] && (cyc == m_acc[i] + 1);
            e_go[i]   = m_occ[i] && !m_hold[i] && (cyc >= m_acc[i] + 2);
            e_busy[i] = m_occ[i];
            if (!m_occ[i] && !ENG_DONE[i]) e_ready = 1;
         end
         check("m_eng_load", ENG_LOAD, e_load);
         check("m_eng_go", ENG_GO, e_go);
         check("m_eng_busy", ENG_BUSY, e_busy);
         check("m_job_ready", JOB_READY, e_ready);
         check("m_res_valid", RES_VALID, m_valid);
         check("m_res_data", RES_DATA, m_data);
         check("m_res_tag", RES_TAG, m_rtag);
         check("m_res_err", RES_ERR, m_rerr);
         check("m_jobs_done", JOBS_DONE, m_jobs);
         check("m_eng_m", ENG_M, m_m);
         check("m_eng_e", ENG_E, m_e);
         check("m_eng_n", ENG_N, m_n);
      end
   end

   // ---------------- directed stimulus (drives at negedge + 1)
   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      step();
      step();
      RESET = 1'b0;
   endtask

   task automatic send_job(input logic [BITS-1:0] m, input logic [BITS-1:0] e,
                           input logic [BITS-1:0] n, input logic [TW-1:0] tag, input int bound);
      bit ok = 0;
      JOB_VALID = 1'b1; JOB_M = m; JOB_E = e; JOB_N = n; JOB_TAG = tag;
      for (int k = 0; k < bound && !ok; k++) begin
         if (JOB_READY) ok = 1;
         step();
      end
      JOB_VALID = 1'b0;
      check("job_accepted", ok, 1);
   endtask

   task automatic get_result(input int bound, output logic [BITS-1:0] d, output logic [TW-1:0] tg,
                             output logic er, output int k);
      bit got = 0;
      RES_READY = 1'b1;
      k = 0; d = '0; tg = '0; er = 1'b0;
      while (!got && k < bound) begin
         if (RES_VALID) begin
            got = 1; d = RES_DATA; tg = RES_TAG; er = RES_ERR;
         end else begin
            k++;
         end
         step();
      end
      check("result_arrived", got, 1);
   endtask

   task automatic finish_eng(input logic [NE-1:0] mask);
      fin_req = mask;
      step();
      fin_req = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [BITS-1:0] d;
      logic [TW-1:0]   tg;
      logic            er;
      int              k;
      RESET = 1'b1; JOB_VALID = 1'b0; JOB_M = '0; JOB_E = '0; JOB_N = '0; JOB_TAG = '0;
      RES_READY = 1'b1; fin_req = '0;
      for (int i = 0; i < NE; i++) begin
         eng_res[i] = 32'hA000_0000 + i; eng_lat[i] = 0; eng_extra[i] = 0;
      end
      step();
      do_reset();
      check("rst_load", ENG_LOAD, 0);
      check("rst_go", ENG_GO, 0);
      check("rst_busy", ENG_BUSY, 0);
      check("rst_valid", RES_VALID, 0);
      check("rst_data", RES_DATA, 0);
      check("rst_err", RES_ERR, 0);
      check("rst_jobs", JOBS_DONE, 0);

      // single job, engine latency 20
      eng_res[0] = 32'h1234; eng_lat[0] = 20;
      send_job(190, 11, 1073602561, 3, 10);
      check("t1_load", ENG_LOAD, 4'b0001);
      check("t1_eng_n", ENG_N, 1073602561);
      step();
      check("t1_go", ENG_GO, 4'b0001);
      get_result(60, d, tg, er, k);
      check("t1_data", d, 32'h1234);
      check("t1_tag", tg, 3);
      check("t1_latency", k, 22);
      check("t1_jobs", JOBS_DONE, 1);
      eng_lat[0] = 0; eng_res[0] = 32'hA000_0000;
      do_reset();

      // five jobs, engines never finish on their own
      for (int i = 0; i < 4; i++) begin
         send_job(100 + i, 3 + i, 1000 + i, TW'(i + 1), 5);
         check("t2_load_order", ENG_LOAD, 4'b0001 << i);
      end
      check("t2_full", JOB_READY, 0);
      JOB_VALID = 1'b1; JOB_M = 105; JOB_E = 8; JOB_N = 1005; JOB_TAG = 5;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t2_stall_ready", JOB_READY, 0);
         check("t2_stall_load", ENG_LOAD, 0);
      end
      finish_eng(4'b0001);
      send_job(105, 8, 1005, 5, 40);
      check("t2_fifth_load", ENG_LOAD, 4'b0001);
      check("t2_jobs", JOBS_DONE, 1);

      // engines 1 and 2 finish together while the consumer stalls
      RES_READY = 1'b0;
      finish_eng(4'b0110);
      repeat (7) step();
      check("t3_hold_valid", RES_VALID, 1);
      check("t3_hold_tag", RES_TAG, 2);
      check("t3_hold_data", RES_DATA, 32'hA000_0001);
      get_result(20, d, tg, er, k);
      check("t3_first_tag", tg, 2);
      check("t3_first_data", d, 32'hA000_0001);
      get_result(20, d, tg, er, k);
      check("t3_second_tag", tg, 3);
      check("t3_second_data", d, 32'hA000_0002);
      check("t3_jobs", JOBS_DONE, 3);

      // engine 2 holds DONE after GO falls; slot 2 must wait for it
      send_job(200, 5, 3001, 6, 5);
      check("t4_load_e1", ENG_LOAD, 4'b0010);
      eng_extra[2] = 2;
      send_job(201, 6, 3002, 7, 5);
      check("t4_load_e2", ENG_LOAD, 4'b0100);
      step();
      finish_eng(4'b0100);
      get_result(20, d, tg, er, k);
      check("t4_tag", tg, 7);
      check("t4_ready_blocked", JOB_READY, 0);
      send_job(202, 7, 3003, 8, 20);
      check("t4_redispatch", ENG_LOAD, 4'b0100);
      eng_extra[2] = 0;

      // reset with three slots busy and one holding a result
      RES_READY = 1'b0;
      step();
      finish_eng(4'b0100);
      repeat (3) step();
      check("t5_pre_busy", ENG_BUSY, 4'b1111);
      check("t5_pre_valid", RES_VALID, 1);
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      check("t5_go", ENG_GO, 0);
      check("t5_valid", RES_VALID, 0);
      check("t5_busy", ENG_BUSY, 0);
      check("t5_jobs", JOBS_DONE, 0);
      RES_READY = 1'b1;
      step();

`ifdef MODEXP_TIMEOUT_EN
      // engine never answers: slot aborts after TO busy cycles
      send_job(7, 9, 11, 9, 5);
      get_result(100, d, tg, er, k);
      check("t6_err", er, 1);
      check("t6_data", d, 32'hFFFF_FFFF);
      check("t6_tag", tg, 9);
      check("t6_latency", k, 52);
`endif

      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
